serial_byte_rx: RTL and testbench

Receives the 1-bit asynchronous serial stream that the SoC emits on its serial data output and assembles it into bytes for the host-side/testbench consumer.
- Frame format: 8N1, LSB first.
- Oversampled by a clock-cycle counter.
- Buffered in a small FIFO behind a valid/ready handshake.
- Reports framing errors and overflow as single-cycle pulses.

---
 rtl/serial_byte_rx_if.sv | 17 +
 rtl/serial_byte_rx.sv | 183 ++++++++++++++++++
 tb/tb_serial_byte_rx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/serial_byte_rx_if.sv
// ---------------------------------------------------------------------------
// serial_byte_rx_if
// Byte stream handshake between the serial receiver FIFO and its consumer.
//   data  : head byte of the receive FIFO (valid while valid is high)
//   valid : FIFO non-empty
//   ready : consumer accepts data when valid && ready
// master : the receiver (drives data/valid, samples ready)
// slave  : the consumer (samples data/valid, drives ready)
// ---------------------------------------------------------------------------
interface serial_byte_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/serial_byte_rx.sv
// ---------------------------------------------------------------------------
// serial_byte_rx
// 8N1, LSB-first asynchronous serial receiver with a small byte FIFO.
// The line is oversampled by a cycle counter: the start bit is re-checked at
// its middle, then each data bit and the stop bit are sampled one bit period
// apart. Good bytes are pushed into a FIFO read through a valid/ready port.
// Ports:
//   wb_clk      : clock, all logic on the rising edge
//   wb_rst_n    : asynchronous active-low reset
//   i_serial    : serial line, idle high
//   rx_bus      : byte output handshake (data / valid / ready)
//   o_frame_err : one-cycle pulse, stop bit sampled low
//   o_overflow  : one-cycle pulse, good byte dropped because the FIFO was full
//   o_busy      : receiver FSM not idle
// ---------------------------------------------------------------------------
module serial_byte_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic              i_serial,
  serial_byte_rx_if.master  rx_bus,
  output logic              o_frame_err,
  output logic              o_overflow,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  // Input synchronizer; flops come out of reset high (idle line) so reset
  // release never looks like a start bit.
  logic rx_meta_reg, rx_s_reg, rx_prev_reg;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= i_serial;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  // Receiver FSM
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             push;
  logic             frame_err_set;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg + 1'b1;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    push          = 1'b0;
    frame_err_set = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_prev_reg && !rx_s_reg) state_next = START;
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            state_next = IDLE;          // too short to be a start bit
          end else begin
            state_next = DATA;
            idx_next   = '0;
          end
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rx_s_reg;
          if (idx_reg == 3'd7) state_next = STOP;
          else                 idx_next   = idx_reg + 3'd1;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_next    = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Hold off a held-low (break) line until it returns high.
        cnt_next = '0;
        if (rx_s_reg) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Receive FIFO. Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [7:0]  mem_reg [FIFO_DEPTH];
  logic        fifo_empty, fifo_full, pop, push_ok;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop        = !fifo_empty && rx_bus.ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
      always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n)
          mem_reg[gi] <= '0;
        else if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi)))
          mem_reg[gi] <= shift_reg;
      end
    end
  endgenerate

  assign rx_bus.data  = mem_reg[rd_ptr_reg[AW-1:0]];
  assign rx_bus.valid = !fifo_empty;

  // Event pulses; a frame error never coincides with a push, so the two
  // pulses are mutually exclusive by construction.
  logic frame_err_reg, overflow_reg;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      frame_err_reg <= frame_err_set;
      overflow_reg  <= push && !push_ok;
    end
  end

  assign o_frame_err = frame_err_reg;
  assign o_overflow  = overflow_reg;
  assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_byte_rx
// Directed test of serial_byte_rx at CLKS_PER_BIT=16, FIFO_DEPTH=4.
// A negedge monitor collects popped bytes and counts event pulses; tests
// compare deltas of those counters against hand-computed values.
// ---------------------------------------------------------------------------
module tb_serial_byte_rx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic serial = 1'b1;
  logic frame_err, overflow, busy;

  serial_byte_rx_if bus ();

  serial_byte_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk      (clk),
    .wb_rst_n    (rst_n),
    .i_serial    (serial),
    .rx_bus      (bus),
    .o_frame_err (frame_err),
    .o_overflow  (overflow),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor
  int         cycle      = 0;
  int         rise_cycle = 0;
  int         valid_hi   = 0;
  int         ferr_cnt   = 0;
  int         ovf_cnt    = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    valid_prev <= bus.valid;
    if (bus.valid && !valid_prev) rise_cycle <= cycle;
    if (bus.valid) valid_hi <= valid_hi + 1;
    if (bus.valid && bus.ready) got_q.push_back(bus.data);
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overflow) ovf_cnt <= ovf_cnt + 1;
    if (frame_err && overflow) check("pulse_exclusive", 32'd1, 32'd0);
  end

  // Stimulus helpers: inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serial = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ferr0, ovf0, vh0, start_cycle;
    logic [7:0] exp_bytes [4];
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'hFF;
    exp_bytes[2] = 8'h3C; exp_bytes[3] = 8'h81;

    bus.ready = 1'b1;

    // Reset state
    tick(3);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(bus.data), 32'd0);
    check("rst_pulses", 32'(frame_err | overflow), 32'd0);
    rst_n = 1'b1;
    tick(100);
    check("idle_valid", 32'(bus.valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_pulses", 32'(ferr_cnt + ovf_cnt + valid_hi), 32'd0);

    // Single byte 0xA5 with latency
    base = got_q.size(); vh0 = valid_hi;
    start_cycle = cycle;
    send_byte(8'hA5, 1'b1);
    tick(20);
    check("a5_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) check("a5_data", 32'(got_q[base]), 32'hA5);
    check("a5_valid_cycles", 32'(valid_hi - vh0), 32'd1);
    check("a5_latency", 32'(rise_cycle - start_cycle), 32'd155);
    check("a5_busy_after", 32'(busy), 32'd0);

    // Overflow: five bytes, no consumer
    bus.ready = 1'b0;
    base = got_q.size(); ovf0 = ovf_cnt; ferr0 = ferr_cnt;
    for (int i = 0; i < 4; i++) send_byte(exp_bytes[i], 1'b1);
    check("ovf_none_before", 32'(ovf_cnt - ovf0), 32'd0);
    check("ovf_head_held", 32'(bus.data), 32'h00);
    send_byte(8'h5A, 1'b1);
    tick(5);
    check("ovf_once", 32'(ovf_cnt - ovf0), 32'd1);
    check("ovf_head_stable", 32'(bus.data), 32'h00);
    check("ovf_no_ferr", 32'(ferr_cnt - ferr0), 32'd0);
    bus.ready = 1'b1;
    tick(8);
    check("ovf_pop_count", 32'(got_q.size() - base), 32'd4);
    if (got_q.size() >= base + 4)
      for (int i = 0; i < 4; i++) check("ovf_pop_data", 32'(got_q[base+i]), 32'(exp_bytes[i]));
    check("ovf_drained", 32'(bus.valid), 32'd0);

    // Framing error followed by a break
    base = got_q.size(); ferr0 = ferr_cnt; ovf0 = ovf_cnt;
    send_byte(8'h55, 1'b0);
    tick(40);
    check("ferr_once", 32'(ferr_cnt - ferr0), 32'd1);
    check("ferr_wait_idle_busy", 32'(busy), 32'd1);
    check("ferr_no_push", 32'(got_q.size() - base), 32'd0);
    check("ferr_no_ovf", 32'(ovf_cnt - ovf0), 32'd0);
    serial = 1'b1;
    tick(4);
    check("ferr_back_idle", 32'(busy), 32'd0);
    send_byte(8'h12, 1'b1);
    tick(4);
    check("after_ferr_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) check("after_ferr_data", 32'(got_q[base]), 32'h12);
    check("after_ferr_no_ferr", 32'(ferr_cnt - ferr0), 32'd1);

    // Short low glitch
    base = got_q.size(); ferr0 = ferr_cnt;
    serial = 1'b0;
    tick(5);
    serial = 1'b1;
    check("glitch_busy", 32'(busy), 32'd1);
    tick(30);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_no_push", 32'(got_q.size() - base), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt - ferr0), 32'd0);

    // Reset mid-frame clears partial byte and FIFO
    bus.ready = 1'b0;
    send_byte(8'h77, 1'b1);
    tick(4);
    check("pre_rst_valid", 32'(bus.valid), 32'd1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    serial = 1'b0;
    tick(8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick(3);
    check("mid_rst_valid_hold", 32'(bus.valid), 32'd0);
    serial = 1'b1;
    rst_n = 1'b1;
    tick(5);
    bus.ready = 1'b1;
    base = got_q.size();
    send_byte(8'h99, 1'b1);
    tick(5);
    check("post_rst_count", 32'(got_q.size() - base), 32'd1);
    if (got_q.size() > base) check("post_rst_data", 32'(got_q[base]), 32'h99);
    check("post_rst_empty", 32'(bus.valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
